// File: rtl/pb_pkg.sv
// pb_pkg: shared types and constants for the push-button conditioner
package pb_pkg;
   localparam int PB_DEBOUNCE_DEFAULT = 500000;
   localparam int PB_NUM_DEFAULT = 5;
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} pb_state_t;
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/pb_channel.sv
// pb_channel: synchroniser, debounce FSM and auto-repeat for one button
module pb_channel
   import pb_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
   parameter int REPEAT_DELAY = 0,
   parameter int REPEAT_PERIOD = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_raw,
   output logic pb_level,
   output logic pb_press,
   output logic pb_release
);
   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam int RW = cnt_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic [RW-1:0] rcnt;
   pb_state_t state;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= '0;
         state <= RELEASED;
         cnt <= '0;
         rcnt <= '0;
         pb_level <= 1'b0;
         pb_press <= 1'b0;
         pb_release <= 1'b0;
      end else begin
         sync <= {sync[0], ~pb_raw};
         pb_press <= 1'b0;
         pb_release <= 1'b0;
         cnt <= (cnt == CW'(DEBOUNCE_CYCLES)) ? cnt : cnt + 1'b1;
         // rcnt counts down to the next repeat; reloaded with the period after each one
         if (REPEAT_DELAY != 0 && (state == HELD || state == RELEASE_WAIT)) begin
            rcnt <= (rcnt == '0) ? RW'(REPEAT_PERIOD - 1) : rcnt - 1'b1;
            pb_press <= (rcnt == '0);
         end
         case (state)
            RELEASED: begin
               cnt <= '0;
               if (sync[1]) state <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!sync[1]) begin
                  state <= RELEASED;
                  cnt <= '0;
               end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                  state <= HELD;
                  cnt <= '0;
                  pb_level <= 1'b1;
                  pb_press <= 1'b1;
                  rcnt <= RW'(REPEAT_DELAY - 1);
               end
            end
            HELD: begin
               cnt <= '0;
               if (!sync[1]) state <= RELEASE_WAIT;
            end
            default: begin
               if (sync[1]) begin
                  state <= HELD;
                  cnt <= '0;
               end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                  state <= RELEASED;
                  cnt <= '0;
                  rcnt <= '0;
                  pb_level <= 1'b0;
                  pb_press <= 1'b0;
                  pb_release <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: rtl/pb_conditioner.sv
// pb_conditioner: debounced levels and press/release pulses for the board buttons
module pb_conditioner
   import pb_pkg::*;
#(
   parameter int NUM_PB = PB_NUM_DEFAULT,
   parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
   parameter int REPEAT_DELAY = 0,
   parameter int REPEAT_PERIOD = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_PB-1:0] PB,
   output logic [NUM_PB-1:0] pb_level,
   output logic [NUM_PB-1:0] pb_press,
   output logic [NUM_PB-1:0] pb_release,
   output logic              pb_any
);
   for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
      pb_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
         .clk(clk),
         .rst_n(rst_n),
         .pb_raw(PB[i]),
         .pb_level(pb_level[i]),
         .pb_press(pb_press[i]),
         .pb_release(pb_release[i])
      );
   end
   assign pb_any = |pb_press;
endmodule

// File: tb/tb_pb_conditioner.sv
// tb_pb_conditioner: directed checks of debounce, pulses, repeat and reset
module tb_pb_conditioner;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] pb_a = '1, pb_b = '1;
   logic [4:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
   logic any_a, any_b;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   pb_conditioner #(.NUM_PB(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .PB(pb_a), .pb_level(lvl_a), .pb_press(prs_a),
      .pb_release(rel_a), .pb_any(any_a));
   pb_conditioner #(.NUM_PB(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .PB(pb_b), .pb_level(lvl_b), .pb_press(prs_b),
      .pb_release(rel_b), .pb_any(any_b));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      pb_a = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset outputs", {lvl_a, prs_a, rel_a, any_a}, 32'h0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         check($sformatf("reset press c=%0d", c), prs_a, (c == 6) ? 5'h1f : 5'h0);
         check($sformatf("reset level c=%0d", c), lvl_a, (c >= 6) ? 5'h1f : 5'h0);
      end
      pb_a = '1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("all release c=%0d", c), rel_a, (c == 6) ? 5'h1f : 5'h0);
         check($sformatf("all level c=%0d", c), lvl_a, (c < 6) ? 5'h1f : 5'h0);
      end
      pb_a = 5'b10111;
      for (int c = 0; c < 32; c++) begin
         if (c == 20) pb_a = '1;
         tick();
         check($sformatf("clean press c=%0d", c), prs_a, (c == 6) ? 5'b01000 : 5'h0);
         check($sformatf("clean release c=%0d", c), rel_a, (c == 26) ? 5'b01000 : 5'h0);
         check($sformatf("clean level c=%0d", c), lvl_a, (c >= 6 && c < 26) ? 5'b01000 : 5'h0);
      end
      for (int c = 0; c < 20; c++) begin
         pb_a = (c < 12 && (c / 2) % 2 == 0) ? 5'b10111 : 5'b11111;
         tick();
         check($sformatf("bounce c=%0d", c), {prs_a, rel_a, lvl_a}, 32'h0);
      end
      pb_a = 5'b00111;
      for (int c = 0; c < 8; c++) begin
         tick();
         check($sformatf("simul press c=%0d", c), prs_a, (c == 6) ? 5'b11000 : 5'h0);
         check($sformatf("simul any c=%0d", c), any_a, (c == 6) ? 1 : 0);
      end
      pb_a = '1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("simul release c=%0d", c), rel_a, (c == 6) ? 5'b11000 : 5'h0);
      end
      pb_a = 5'b10111;
      repeat (8) tick();
      check("midhold level", lvl_a, 5'b01000);
      rst_n = 1'b0;
      pb_a = '1;
      tick();
      check("midhold reset", {lvl_a, rel_a, prs_a}, 32'h0);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("after reset c=%0d", c), {lvl_a, rel_a}, 32'h0);
      end
      pb_b = 5'b11110;
      for (int c = 0; c < 46; c++) begin
         if (c == 35) pb_b = '1;
         tick();
         check($sformatf("repeat press c=%0d", c), prs_b,
               (c inside {6, 16, 21, 26, 31, 36}) ? 5'b00001 : 5'h0);
         check($sformatf("repeat release c=%0d", c), rel_b, (c == 41) ? 5'b00001 : 5'h0);
         if (c == 16) check("repeat any", any_b, 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
